// File: rtl/cricket_delivery_ctrl.sv
// cricket_delivery_ctrl: samples the LFSR on each bowl request, decodes the delivery
// and keeps runs/wickets/balls/overs, with a lockout between deliveries.
module cricket_delivery_ctrl #(
  parameter int MAX_OVERS      = 2,
  parameter int MAX_WICKETS    = 10,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic       clk_fpga,
  input  logic       reset,
  input  logic       bowl_btn,
  input  logic [3:0] rnd,
  output logic [8:0] runs,
  output logic [3:0] wickets,
  output logic [2:0] balls,
  output logic [3:0] overs,
  output logic [3:0] last_outcome,
  output logic       outcome_valid,
  output logic       busy,
  output logic       innings_over
);
  typedef enum logic [2:0] {IDLE, SAMPLE, UPDATE, COOL, DONE} state_t;
  state_t      state_q, state_d;
  logic        bowl_prev_q;
  logic [3:0]  rnd_q, rnd_d;
  logic [8:0]  runs_q, runs_d;
  logic [3:0]  wickets_q, wickets_d;
  logic [2:0]  balls_q, balls_d;
  logic [3:0]  overs_q, overs_d;
  logic [3:0]  last_q, last_d;
  logic        valid_q, valid_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  code;
  logic [2:0]  add;
  logic        extra, legal, wkt, last_ball, ended;
  logic [9:0]  runs_sum;
  always_comb begin
    code = rnd_q <= 4'd2  ? 4'd0 :
           rnd_q <= 4'd6  ? 4'd1 :
           rnd_q <= 4'd9  ? 4'd2 :
           rnd_q == 4'd10 ? 4'd3 :
           rnd_q == 4'd11 ? 4'd4 :
           rnd_q == 4'd12 ? 4'd6 :
           rnd_q == 4'd13 ? 4'd8 :
           rnd_q == 4'd14 ? 4'd9 : 4'd15;
    extra = code == 4'd8 || code == 4'd9;
    add = extra ? 3'd1 : code == 4'd15 ? 3'd0 : code[2:0];
    legal = !extra;
    wkt = code == 4'd15;
    last_ball = balls_q == 3'd5;
    runs_sum = {1'b0, runs_q} + {7'd0, add};
    ended = wickets_q == 4'(MAX_WICKETS) || overs_q == 4'(MAX_OVERS);
  end
  always_comb begin
    state_d = state_q;
    rnd_d = rnd_q;
    runs_d = runs_q;
    wickets_d = wickets_q;
    balls_d = balls_q;
    overs_d = overs_q;
    last_d = last_q;
    valid_d = 1'b0;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: state_d = bowl_btn && !bowl_prev_q ? SAMPLE : IDLE;
      SAMPLE: begin
        rnd_d = rnd;
        state_d = UPDATE;
      end
      UPDATE: begin
        runs_d = runs_sum[9] ? 9'd511 : runs_sum[8:0];
        last_d = code;
        wickets_d = wickets_q + {3'd0, wkt};
        balls_d = !legal ? balls_q : last_ball ? 3'd0 : balls_q + 3'd1;
        overs_d = overs_q + {3'd0, legal && last_ball};
        valid_d = 1'b1;
        cnt_d = 16'd0;
        state_d = COOL;
      end
      COOL: begin
        cnt_d = cnt_q + 16'd1;
        state_d = cnt_q != 16'(LOCKOUT_CYCLES - 1) ? COOL : ended ? DONE : IDLE;
      end
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      state_q <= IDLE;
      bowl_prev_q <= 1'b0;
      rnd_q <= 4'd0;
      runs_q <= 9'd0;
      wickets_q <= 4'd0;
      balls_q <= 3'd0;
      overs_q <= 4'd0;
      last_q <= 4'd0;
      valid_q <= 1'b0;
      cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      bowl_prev_q <= bowl_btn;
      rnd_q <= rnd_d;
      runs_q <= runs_d;
      wickets_q <= wickets_d;
      balls_q <= balls_d;
      overs_q <= overs_d;
      last_q <= last_d;
      valid_q <= valid_d;
      cnt_q <= cnt_d;
    end
  end
  assign runs = runs_q;
  assign wickets = wickets_q;
  assign balls = balls_q;
  assign overs = overs_q;
  assign last_outcome = last_q;
  assign outcome_valid = valid_q;
  assign busy = state_q != IDLE;
  assign innings_over = state_q == DONE;
endmodule

// File: tb/tb_cricket_delivery_ctrl.sv
// tb_cricket_delivery_ctrl: two controllers (wicket-limited and over-limited) share
// one stimulus stream and are checked against a per-ball scoring model.
module tb_cricket_delivery_ctrl;
  localparam int L = 16;
  logic clk = 1'b0, reset = 1'b1, bowl_btn = 1'b0, hold_rnd = 1'b0;
  logic [3:0] rnd_force = 4'd0, rnd_rand = 4'd0, rnd;
  logic [8:0] runs_a, runs_b;
  logic [3:0] wickets_a, wickets_b, overs_a, overs_b, last_a, last_b;
  logic [2:0] balls_a, balls_b;
  logic valid_a, valid_b, busy_a, busy_b, over_a, over_b;
  int checks = 0, failures = 0, pulses_a = 0, pulses_b = 0;
  typedef struct {int runs; int wk; int balls; int overs; int last; bit done;} mdl_t;
  mdl_t ma, mb;
  assign rnd = hold_rnd ? rnd_force : rnd_rand;
  cricket_delivery_ctrl #(.MAX_OVERS(15), .MAX_WICKETS(2), .LOCKOUT_CYCLES(L)) dut_a (
    .clk_fpga(clk), .reset(reset), .bowl_btn(bowl_btn), .rnd(rnd), .runs(runs_a),
    .wickets(wickets_a), .balls(balls_a), .overs(overs_a), .last_outcome(last_a),
    .outcome_valid(valid_a), .busy(busy_a), .innings_over(over_a));
  cricket_delivery_ctrl #(.MAX_OVERS(1), .MAX_WICKETS(15), .LOCKOUT_CYCLES(L)) dut_b (
    .clk_fpga(clk), .reset(reset), .bowl_btn(bowl_btn), .rnd(rnd), .runs(runs_b),
    .wickets(wickets_b), .balls(balls_b), .overs(overs_b), .last_outcome(last_b),
    .outcome_valid(valid_b), .busy(busy_b), .innings_over(over_b));
  initial forever #5 clk = ~clk;
  initial forever begin
    @(negedge clk);
    rnd_rand = 4'($urandom_range(15));
  end
  always @(posedge clk) begin
    if (valid_a === 1'b1) pulses_a++;
    if (valid_b === 1'b1) pulses_b++;
  end
  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
  function automatic mdl_t apply(mdl_t m, int r, int mo, int mw);
    int code_of[16] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 3, 4, 6, 8, 9, 15};
    int runs_of[16] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 3, 4, 6, 1, 1, 0};
    int legal_balls;
    if (m.done) return m;
    m.runs = m.runs + runs_of[r] > 511 ? 511 : m.runs + runs_of[r];
    m.last = code_of[r];
    if (r == 15) m.wk++;
    if (r != 13 && r != 14) begin
      legal_balls = m.overs * 6 + m.balls + 1;
      m.overs = legal_balls / 6;
      m.balls = legal_balls % 6;
    end
    m.done = m.wk == mw || m.overs == mo;
    return m;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic chk_state(input string tag);
    chk({tag, ":runs_a"}, 32'(runs_a), ma.runs);
    chk({tag, ":wk_a"}, 32'(wickets_a), ma.wk);
    chk({tag, ":balls_a"}, 32'(balls_a), ma.balls);
    chk({tag, ":overs_a"}, 32'(overs_a), ma.overs);
    chk({tag, ":last_a"}, 32'(last_a), ma.last);
    chk({tag, ":runs_b"}, 32'(runs_b), mb.runs);
    chk({tag, ":wk_b"}, 32'(wickets_b), mb.wk);
    chk({tag, ":balls_b"}, 32'(balls_b), mb.balls);
    chk({tag, ":overs_b"}, 32'(overs_b), mb.overs);
    chk({tag, ":last_b"}, 32'(last_b), mb.last);
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bowl_btn = 1'b0;
    hold_rnd = 1'b0;
    step(2);
    reset = 1'b0;
    ma = '{0, 0, 0, 0, 0, 0};
    mb = '{0, 0, 0, 0, 0, 0};
  endtask
  task automatic bowl(input int r_in, input bit hold);
    int r, na, nb;
    bit pa, pb;
    r = r_in < 0 ? int'($urandom_range(15)) : r_in;
    pa = ma.done;
    pb = mb.done;
    na = pulses_a;
    nb = pulses_b;
    rnd_force = 4'(r);
    hold_rnd = 1'b1;
    bowl_btn = 1'b1;
    step(1);
    chk("sample_busy_a", 32'(busy_a), 1);
    chk("sample_busy_b", 32'(busy_b), 1);
    step(1);
    hold_rnd = 1'b0;
    chk("update_valid_a", 32'(valid_a), 0);
    chk("update_valid_b", 32'(valid_b), 0);
    chk_state("pre");
    ma = apply(ma, r, 15, 2);
    mb = apply(mb, r, 1, 15);
    step(1);
    chk("valid_a", 32'(valid_a), 32'(!pa));
    chk("valid_b", 32'(valid_b), 32'(!pb));
    chk_state("post");
    if (!hold) bowl_btn = 1'b0;
    step(1);
    chk("pulse_end_a", 32'(valid_a), 0);
    chk("pulse_end_b", 32'(valid_b), 0);
    if (!hold) bowl_btn = 1'b1;
    step(1);
    if (!hold) bowl_btn = 1'b0;
    step(L - 3);
    chk("cool_busy_a", 32'(busy_a), 1);
    chk("cool_over_a", 32'(over_a), 32'(pa));
    chk("cool_over_b", 32'(over_b), 32'(pb));
    step(1);
    chk("end_busy_a", 32'(busy_a), 32'(ma.done));
    chk("end_over_a", 32'(over_a), 32'(ma.done));
    chk("end_busy_b", 32'(busy_b), 32'(mb.done));
    chk("end_over_b", 32'(over_b), 32'(mb.done));
    chk("pulses_a", 32'(pulses_a), 32'(na + (pa ? 0 : 1)));
    chk("pulses_b", 32'(pulses_b), 32'(nb + (pb ? 0 : 1)));
  endtask
  initial begin
    int n;
    do_reset();
    chk_state("reset");
    chk("reset_valid", 32'(valid_a), 0);
    chk("reset_busy", 32'(busy_a), 0);
    chk("reset_over", 32'(over_a), 0);
    bowl(12, 1'b0);
    chk("six_runs", 32'(runs_a), 6);
    chk("six_balls", 32'(balls_a), 1);
    chk("six_last", 32'(last_a), 6);
    do_reset();
    for (int i = 0; i < 6; i++) bowl(0, 1'b0);
    chk("over_overs", 32'(overs_a), 1);
    chk("over_balls", 32'(balls_a), 0);
    chk("over_runs", 32'(runs_a), 0);
    chk("over_limit_b", 32'(over_b), 1);
    bowl(13, 1'b0);
    chk("wide_runs", 32'(runs_a), 1);
    chk("wide_balls", 32'(balls_a), 0);
    chk("wide_last", 32'(last_a), 8);
    chk("wide_frozen_b", 32'(runs_b), 0);
    do_reset();
    bowl(-1, 1'b1);
    n = pulses_a;
    step(100);
    chk("hold_pulses", 32'(pulses_a), 32'(n));
    chk("hold_busy", 32'(busy_a), 0);
    bowl_btn = 1'b0;
    step(1);
    do_reset();
    bowl(15, 1'b0);
    bowl(15, 1'b0);
    chk("wkt_count", 32'(wickets_a), 2);
    chk("wkt_done", 32'(over_a), 1);
    bowl(12, 1'b0);
    bowl(-1, 1'b0);
    chk("wkt_frozen_runs", 32'(runs_a), 0);
    do_reset();
    for (int i = 0; i < 86; i++) begin
      bowl(12, 1'b0);
      if (i % 5 == 4) bowl(14, 1'b0);
    end
    chk("sat_runs", 32'(runs_a), 511);
    bowl(12, 1'b0);
    chk("sat_hold", 32'(runs_a), 511);
    do_reset();
    bowl_btn = 1'b1;
    step(1);
    bowl_btn = 1'b0;
    step(4);
    chk("midcool_busy", 32'(busy_a), 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    ma = '{0, 0, 0, 0, 0, 0};
    mb = '{0, 0, 0, 0, 0, 0};
    chk_state("midcool_reset");
    chk("midcool_valid", 32'(valid_a), 0);
    chk("midcool_busy0", 32'(busy_a), 0);
    chk("midcool_over", 32'(over_a), 0);
    bowl(-1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      do_reset();
      for (int i = 0; i < 12; i++) bowl(-1, 1'b0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
